// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: dispatch-stage stall and exception-recovery controller.
// It freezes the front end for resource hazards. On a retiring exception it
// raises a one-cycle flush and then holds the front end for RECOV_CYC cycles
// while the SRAT and freelist restore from the ARAT.
// Optional feature macro: DISPATCH_STALL_CNT_EN. When it is defined, the
// block counts freeze_front cycles in stall_cnt and saturates at all-ones.
// When it is undefined, stall_cnt is tied to zero.
module dispatch_ctrl #(
    parameter int RECOV_CYC = 2,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_pc_r_r,
    input  logic [5:0]       Type_r,
    input  logic             full_PRF,
    input  logic             full_ROB,
    input  logic             full_RS_add,
    input  logic             full_RS_mul,
    input  logic             full_RS_agu,
    input  logic             full_LSQ,
    input  logic             busy_mem,
    input  logic [2:0]       ready_ret,
    input  logic [2:0]       excep_ret,
    output logic             freeze_front,
    output logic             freeze_back,
    output logic             flush,
    output logic [2:0]       stall_cause,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] rcnt_q, rcnt_d;
    logic       flush_q, flush_d;

    logic need_add, need_mul, need_mem;
    logic exc;
    logic st_prf, st_rob, st_add, st_mul, st_agu, st_lsq;
    logic res_stall;

    // Decode which execution resources the rename bundle needs, and detect a retiring exception
    always_comb begin
        need_add = 1'b0;
        need_mul = 1'b0;
        need_mem = 1'b0;
        exc      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            need_add = need_add | (Type_r[2*i+1 -: 2] == 2'b00);
            need_mul = need_mul | (Type_r[2*i+1 -: 2] == 2'b01);
            need_mem = need_mem | Type_r[2*i+1];
            exc      = exc | (ready_ret[i] & excep_ret[i]);
        end
    end

    // Individual stall terms, gated by a valid bundle
    always_comb begin
        st_prf    = valid_pc_r_r & full_PRF;
        st_rob    = valid_pc_r_r & full_ROB;
        st_add    = valid_pc_r_r & need_add & full_RS_add;
        st_mul    = valid_pc_r_r & need_mul & full_RS_mul;
        st_agu    = valid_pc_r_r & need_mem & full_RS_agu;
        st_lsq    = valid_pc_r_r & need_mem & full_LSQ;
        res_stall = st_prf | st_rob | st_add | st_mul | st_agu | st_lsq;
    end

    // Next-state logic. An exception seen outside RUN is dropped because the ROB is already flushed
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        flush_d = 1'b0;
        case (state_q)
            RUN: begin
                if (exc) begin
                    state_d = FLUSH;
                    flush_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d = RECOVER;
                rcnt_d  = 4'(RECOV_CYC);
            end
            RECOVER: begin
                if (rcnt_q <= 4'd1) begin
                    state_d = RUN;
                    rcnt_d  = 4'd0;
                end else begin
                    rcnt_d  = rcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = RUN;
                rcnt_d  = 4'd0;
            end
        endcase
    end

    // FSM registers. The flush pulse is registered so it never follows the retire inputs combinationally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            rcnt_q  <= 4'd0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rcnt_q  <= rcnt_d;
            flush_q <= flush_d;
        end
    end

    // Freeze outputs and the prioritised stall reason
    always_comb begin
        flush        = flush_q;
        freeze_front = (state_q != RUN) | res_stall;
        freeze_back  = (state_q == FLUSH) | busy_mem;
        if (state_q != RUN) stall_cause = 3'd7;
        else if (st_prf)    stall_cause = 3'd1;
        else if (st_rob)    stall_cause = 3'd2;
        else if (st_add)    stall_cause = 3'd3;
        else if (st_mul)    stall_cause = 3'd4;
        else if (st_agu)    stall_cause = 3'd5;
        else if (st_lsq)    stall_cause = 3'd6;
        else                stall_cause = 3'd0;
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles with the front end frozen
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (freeze_front && (stall_cnt_q != {CNT_W{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) stall_cnt_q <= '0;
        else      stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl. It uses a table of RUN-state hazard vectors and
// hand-written sequences for flush/recover, reset abort and the stall counter.
module tb_dispatch_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             valid_pc_r_r;
    logic [5:0]       Type_r;
    logic             full_PRF, full_ROB, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ;
    logic             busy_mem;
    logic [2:0]       ready_ret, excep_ret;
    logic             freeze_front, freeze_back, flush;
    logic [2:0]       stall_cause;
    logic [CNT_W-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    dispatch_ctrl #(.RECOV_CYC(2), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .valid_pc_r_r(valid_pc_r_r), .Type_r(Type_r),
        .full_PRF(full_PRF), .full_ROB(full_ROB), .full_RS_add(full_RS_add),
        .full_RS_mul(full_RS_mul), .full_RS_agu(full_RS_agu), .full_LSQ(full_LSQ),
        .busy_mem(busy_mem), .ready_ret(ready_ret), .excep_ret(excep_ret),
        .freeze_front(freeze_front), .freeze_back(freeze_back), .flush(flush),
        .stall_cause(stall_cause), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [5:0] typ;
        logic [5:0] full;   // {PRF, ROB, RS_add, RS_mul, RS_agu, LSQ}
        logic       busy;
        logic       e_ff;
        logic       e_fb;
        logic [2:0] e_cause;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // advance to just after a rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        valid_pc_r_r = 1'b0; Type_r = 6'd0;
        {full_PRF, full_ROB, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ} = 6'd0;
        busy_mem = 1'b0; ready_ret = 3'd0; excep_ret = 3'd0;
    endtask

    task automatic chk_out(input string name, input logic ff, input logic fb,
                           input logic fl, input logic [2:0] cause);
        chk({name, ".freeze_front"}, 32'(freeze_front), 32'(ff));
        chk({name, ".freeze_back"},  32'(freeze_back),  32'(fb));
        chk({name, ".flush"},        32'(flush),        32'(fl));
        chk({name, ".stall_cause"},  32'(stall_cause),  32'(cause));
    endtask

    initial begin
        vecs[0] = '{1'b0, 6'b000000, 6'b111111, 1'b0, 1'b0, 1'b0, 3'd0}; // invalid bundle ignores full flags
        vecs[1] = '{1'b1, 6'b000000, 6'b000100, 1'b0, 1'b0, 1'b0, 3'd0}; // MUL full, no MUL needed
        vecs[2] = '{1'b1, 6'b000000, 6'b001100, 1'b0, 1'b1, 1'b0, 3'd3}; // RS_add full
        vecs[3] = '{1'b1, 6'b000010, 6'b100001, 1'b0, 1'b1, 1'b0, 3'd1}; // PRF beats LSQ
        vecs[4] = '{1'b1, 6'b000010, 6'b000001, 1'b0, 1'b1, 1'b0, 3'd6}; // LSQ only
        vecs[5] = '{1'b1, 6'b000000, 6'b010000, 1'b0, 1'b1, 1'b0, 3'd2}; // ROB
        vecs[6] = '{1'b1, 6'b000100, 6'b000100, 1'b1, 1'b1, 1'b1, 3'd4}; // slot1 MUL, busy mem
        vecs[7] = '{1'b1, 6'b110000, 6'b000011, 1'b0, 1'b1, 1'b0, 3'd5}; // AGU beats LSQ
        vecs[8] = '{1'b1, 6'b010101, 6'b001011, 1'b1, 1'b0, 1'b1, 3'd0}; // all MUL, only add/mem full
        vecs[9] = '{1'b1, 6'b001000, 6'b001000, 1'b0, 1'b1, 1'b0, 3'd3}; // slot0/2 ADD with LS slot1

        idle_inputs();
        rst = 1'b0;
        #12;
        chk_out("reset", 1'b0, 1'b0, 1'b0, 3'd0);
        chk("reset.stall_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        tick();

        // table-driven RUN hazards
        for (int i = 0; i < 10; i++) begin
            valid_pc_r_r = vecs[i].valid;
            Type_r       = vecs[i].typ;
            {full_PRF, full_ROB, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ} = vecs[i].full;
            busy_mem     = vecs[i].busy;
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_ff, vecs[i].e_fb, 1'b0, vecs[i].e_cause);
            tick();
        end

        // exception -> FLUSH -> RECOVER x2 -> RUN
        idle_inputs();
        ready_ret = 3'b010; excep_ret = 3'b010;
        #1;
        chk_out("exc.same_cycle", 1'b0, 1'b0, 1'b0, 3'd0);
        tick();
        ready_ret = 3'd0; excep_ret = 3'd0;
        #1;
        chk_out("exc.flush", 1'b1, 1'b1, 1'b1, 3'd7);
        tick(); #1;
        chk_out("exc.rec1", 1'b1, 1'b0, 1'b0, 3'd7);
        tick(); #1;
        chk_out("exc.rec2", 1'b1, 1'b0, 1'b0, 3'd7);
        tick(); #1;
        chk_out("exc.run", 1'b0, 1'b0, 1'b0, 3'd0);

        // exception together with a resource stall: the stall still shows this cycle
        valid_pc_r_r = 1'b1; full_ROB = 1'b1;
        ready_ret = 3'b001; excep_ret = 3'b001;
        #1;
        chk_out("exc_stall.same", 1'b1, 1'b0, 1'b0, 3'd2);
        tick();
        idle_inputs();
        #1;
        chk_out("exc_stall.flush", 1'b1, 1'b1, 1'b1, 3'd7);
        tick(); #1;
        // a second exception during RECOVER is ignored, and busy_mem passes through
        ready_ret = 3'b100; excep_ret = 3'b100; busy_mem = 1'b1;
        #1;
        chk_out("exc_rec.rec1", 1'b1, 1'b1, 1'b0, 3'd7);
        tick();
        ready_ret = 3'd0; excep_ret = 3'd0; busy_mem = 1'b0;
        #1;
        chk_out("exc_rec.rec2", 1'b1, 1'b0, 1'b0, 3'd7);
        tick(); #1;
        chk_out("exc_rec.run", 1'b0, 1'b0, 1'b0, 3'd0);
        tick(); #1;
        chk_out("exc_rec.noflush", 1'b0, 1'b0, 1'b0, 3'd0);

        // reset during RECOVER aborts recovery
        ready_ret = 3'b001; excep_ret = 3'b001;
        tick();
        idle_inputs();
        tick(); // now in RECOVER
        valid_pc_r_r = 1'b1; full_ROB = 1'b1;
        #1;
        chk("rst_abort.pre_cause", 32'(stall_cause), 32'd7);
        rst = 1'b0;
        #1;
        chk_out("rst_abort.low", 1'b1, 1'b0, 1'b0, 3'd2);
        chk("rst_abort.stall_cnt", 32'(stall_cnt), 32'd0);
        #3 rst = 1'b1;
        tick(); #1;
        chk_out("rst_abort.after", 1'b1, 1'b0, 1'b0, 3'd2);
        full_ROB = 1'b0;
        #1;
        chk_out("rst_abort.clear", 1'b0, 1'b0, 1'b0, 3'd0);

        // stall counter: 20 frozen cycles from reset
        rst = 1'b0;
        #2 rst = 1'b1;
        valid_pc_r_r = 1'b1; full_PRF = 1'b1;
        for (int c = 0; c < 20; c++) tick();
`ifdef DISPATCH_STALL_CNT_EN
        chk("stall_cnt.sat", 32'(stall_cnt), 32'd15);
`else
        chk("stall_cnt.zero", 32'(stall_cnt), 32'd0);
`endif
        idle_inputs();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // guard against a hung run
    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dispatch_ctrl.md
DISPATCH_CTRL -- requirements
Module: dispatch_ctrl

Interface
REQ-001 Parameter RECOV_CYC, default 2: cycles front end stays frozen after a flush while SRAT/freelist restore from ARAT; legal range 1..15.
REQ-002 Parameter CNT_W, default 16: width of the stall counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 valid_pc_r_r  in  1  rename-stage bundle is valid.
REQ-006 Type_r  in  6  packed slot types, slot i at bits [2i+1:2i]; 00 ADD, 01 MUL, 1x LS (needs AGU and LSQ).
REQ-007 full_PRF, full_ROB, full_RS_add, full_RS_mul, full_RS_agu, full_LSQ  in  1 each  resource-full flags.
REQ-008 busy_mem  in  1  data memory cannot accept an LSQ issue this cycle.
REQ-009 ready_ret, excep_ret  in  3 each  per-slot ROB retire ready and exception flags.
REQ-010 freeze_front  out  1  hold IF/ID/rename registers, PC, SRAT and RS/LSQ writes.
REQ-011 freeze_back  out  1  block RS/LSQ issue.
REQ-012 flush  out  1  one-cycle pipeline flush and ARAT restore pulse.
REQ-013 stall_cause  out  3  reason for current freeze_front.
REQ-014 stall_cnt  out  CNT_W  count of cycles with freeze_front=1.

Function
REQ-015 FSM states RUN, FLUSH, RECOVER; state, flush and recovery counter are registers.
REQ-016 need_add/need_mul/need_mem: OR over the 3 slots of the matching Type_r encoding.
REQ-017 res_stall = valid_pc_r_r & (full_PRF | full_ROB | need_add&full_RS_add | need_mul&full_RS_mul | need_mem&(full_RS_agu|full_LSQ)).
REQ-018 exc = OR over i of (ready_ret[i] & excep_ret[i]).
REQ-019 RUN: freeze_front = res_stall, combinational (same cycle); freeze_back = busy_mem; flush = 0.
REQ-020 RUN with exc=1: next state FLUSH; takes priority over res_stall, which still drives freeze_front in that cycle.
REQ-021 FLUSH: lasts exactly 1 cycle; flush=1, freeze_front=1, freeze_back=1; next state RECOVER; counter loaded with RECOV_CYC.
REQ-022 RECOVER: freeze_front=1, freeze_back=busy_mem, flush=0; counter decrements each cycle; at count 1 next state RUN; total RECOVER duration = RECOV_CYC cycles.
REQ-023 exc in FLUSH or RECOVER is ignored (ROB contents already flushed).
REQ-024 stall_cause priority encode: 7 when state!=RUN; otherwise 1 PRF, 2 ROB, 3 RS_add, 4 RS_mul, 5 RS_agu, 6 LSQ, in that order among stall terms contributing to res_stall; 0 when freeze_front=0.
REQ-025 valid_pc_r_r=0 in RUN: freeze_front=0 regardless of full flags.
REQ-026 flush is registered; it never asserts combinationally from ready_ret/excep_ret.

Reset
REQ-027 rst=0 asynchronously forces state RUN, counter 0, flush 0, stall_cnt 0; combinational outputs then follow RUN rules.
REQ-028 rst asserted mid-FLUSH/RECOVER aborts recovery; after release block is in RUN with no residual flush pulse.

Configuration
REQ-029 Macro DISPATCH_STALL_CNT_EN: defined -> stall_cnt increments by 1 on each cycle freeze_front=1, saturating at all-ones.
REQ-030 Macro not defined -> stall_cnt constant 0 and no counter flops are synthesised; all other behaviour identical.

Verification
REQ-031 valid_pc_r_r=1, Type_r=6'b000000, full_RS_mul=1 -> freeze_front=0, stall_cause=0; then set full_RS_add=1 -> freeze_front=1 same cycle, stall_cause=3.
REQ-032 valid_pc_r_r=1, full_PRF=1 and full_LSQ=1, Type_r slot0=10 -> stall_cause=1; drop full_PRF -> stall_cause=6.
REQ-033 RECOV_CYC=2, ready_ret=3'b010, excep_ret=3'b010 for 1 cycle in RUN -> next cycle flush=1, freeze_back=1; following 2 cycles freeze_front=1, stall_cause=7; then RUN.
REQ-034 exc pulse during RECOVER -> no second flush; RUN reached at original time.
REQ-035 rst low during RECOVER -> freeze_front follows res_stall immediately, flush=0, stall_cnt=0.
REQ-036 DISPATCH_STALL_CNT_EN defined, CNT_W=4, freeze_front held 20 cycles -> stall_cnt=15; undefined -> stall_cnt=0 throughout.
